// File: rtl/mult_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq_if
//  Description : Request/response bundle for the mult_seq Booth multiplier.
//                master = requester (decode stage), slave = multiplier.
//  Signals     : start, multiplicand, multiplier   (master -> slave)
//                busy, result_rdy, result, overflow (slave -> master)
//                result_hi (slave -> master, only with MULT_SEQ_HI_EN)
//  Macro       : MULT_SEQ_HI_EN adds result_hi.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             result_rdy;
    logic [WIDTH-1:0] result;
    logic             overflow;
`ifdef MULT_SEQ_HI_EN
    logic [WIDTH-1:0] result_hi;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, result_rdy, result, overflow, result_hi
    );
    modport slave (
        input  start, multiplicand, multiplier,
        output busy, result_rdy, result, overflow, result_hi
    );
`else
    modport master (
        output start, multiplicand, multiplier,
        input  busy, result_rdy, result, overflow
    );
    modport slave (
        input  start, multiplicand, multiplier,
        output busy, result_rdy, result, overflow
    );
`endif
endinterface
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq
//  Description : Multi-cycle signed radix-2 Booth multiplier. One add,
//                subtract or skip per cycle followed by an arithmetic right
//                shift of {acc, q, q_1}. Returns the low product word, a
//                one-cycle ready pulse and a signed-overflow flag.
//  Ports       : clock      - system clock, rising edge
//                reset_n    - asynchronous assert, active-low reset
//                bus        - mult_seq_if.slave (start, operands, busy,
//                             result_rdy, result, overflow[, result_hi])
//  Parameters  : WIDTH (even, >= 4), CNT_W (2**CNT_W > WIDTH)
//  Macro       : MULT_SEQ_HI_EN - adds result_hi, the upper product word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clock,
    input  logic      reset_n,
    mult_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q1_q, q1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               rdy_q, rdy_d;
`ifdef MULT_SEQ_HI_EN
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
`endif

    // One extra bit keeps the true sign of acc +/- mcand, which is what the
    // arithmetic shift must replicate (matters for the most-negative mcand).
    logic [WIDTH:0]     acc_ext;
    logic [WIDTH:0]     mcand_ext;
    logic [WIDTH:0]     booth_sum;

    always_comb begin
        acc_ext   = {acc_q[WIDTH-1], acc_q};
        mcand_ext = {mcand_q[WIDTH-1], mcand_q};
        unique case ({q_q[0], q1_q})
            2'b01:   booth_sum = acc_ext + mcand_ext;
            2'b10:   booth_sum = acc_ext + ~mcand_ext + {{WIDTH{1'b0}}, 1'b1};
            default: booth_sum = acc_ext;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        q_d        = q_q;
        q1_d       = q1_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        rdy_d      = 1'b0;
`ifdef MULT_SEQ_HI_EN
        result_hi_d = result_hi_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // rdy_q marks the pulse cycle; a start seen there is dropped.
                if (bus.start && !rdy_q) begin
                    mcand_d = bus.multiplicand;
                    acc_d   = '0;
                    q_d     = bus.multiplier;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = booth_sum[WIDTH:1];
                q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_d   = q_q;
                // Product fits in WIDTH signed bits only if acc is pure sign
                // extension of the low word.
                overflow_d = (acc_q != {WIDTH{q_q[WIDTH-1]}});
                rdy_d      = 1'b1;
`ifdef MULT_SEQ_HI_EN
                result_hi_d = acc_q;
`endif
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mcand_q    <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            q1_q       <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            rdy_q      <= 1'b0;
`ifdef MULT_SEQ_HI_EN
            result_hi_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            q1_q       <= q1_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            rdy_q      <= rdy_d;
`ifdef MULT_SEQ_HI_EN
            result_hi_q <= result_hi_d;
`endif
        end
    end

    // busy also covers the pulse cycle so the requester sees the unit as
    // unavailable whenever a start would be ignored.
    assign bus.busy       = (state_q != S_IDLE) || rdy_q;
    assign bus.result_rdy = rdy_q;
    assign bus.result     = result_q;
    assign bus.overflow   = overflow_q;
`ifdef MULT_SEQ_HI_EN
    assign bus.result_hi  = result_hi_q;
`endif

endmodule
`default_nettype wire
